// File: rtl/fft_pkg.sv
// Shared types for the FFT datapath: complex sample format, default length,
// and the input loader's state encoding.
package fft_pkg;

    localparam int FFT_N = 8;

    // Q1.15 complex sample: a = real, b = imaginary
    typedef struct packed {
        logic signed [15:0] a;
        logic signed [15:0] b;
    } complex_16;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        KICK = 2'd1,
        BUSY = 2'd2
    } loader_state_e;

endpackage

// File: rtl/bit_reverse.sv
// Combinational address bit reversal over AW bits (DIT input ordering).
module bit_reverse #(
    parameter int AW = 3
) (
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] rev
);

    for (genvar i = 0; i < AW; i++) begin : g_rev
        assign rev[i] = addr[AW-1-i];
    end

endmodule

// File: rtl/fft_input_loader.sv
// FFT input loader: accepts a frame of N streamed samples, writes them into
// the FFT data memory one cycle after acceptance, then kicks the address
// generator and waits for it to finish before taking the next frame.
// Build option: define FFT_LOADER_BITREV_EN to write in bit-reversed address
// order; otherwise samples are written in natural order.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  complex_16     in_data,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output complex_16     mem_wdata,
    output logic          fft_start,
    input  logic          fft_finish,
    output logic          frame_err,
    output logic          busy
);

    loader_state_e state, state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] wr_addr;
    logic          wr_pending_last;
    logic          accept;
    logic          cnt_at_end;

    assign cnt_at_end = (cnt == AW'(N - 1));
    assign accept     = in_valid && in_ready;

`ifdef FFT_LOADER_BITREV_EN
    bit_reverse #(.AW(AW)) u_bit_reverse (
        .addr (cnt),
        .rev  (wr_addr)
    );
`else
    assign wr_addr = cnt;
`endif

    // Next-state and state-decoded outputs; outputs are forced low in reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        fft_start = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                in_ready = rst_n && !wr_pending_last;
                if (wr_pending_last) state_nxt = KICK;
            end
            KICK: begin
                fft_start = rst_n;
                busy      = rst_n;
                state_nxt = BUSY;
            end
            BUSY: begin
                busy = rst_n;
                if (fft_finish) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Sample counter and final-write marker (holds off in_ready for the last write).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt             <= '0;
            wr_pending_last <= 1'b0;
        end else begin
            wr_pending_last <= accept && cnt_at_end;
            if (accept)
                cnt <= cnt + AW'(1);
            else if (state == BUSY && fft_finish)
                cnt <= '0;
        end
    end

    // Memory write port and framing check, one cycle behind acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            frame_err <= 1'b0;
        end else begin
            mem_we    <= accept;
            frame_err <= accept && (in_last != cnt_at_end);
            if (accept) begin
                mem_addr  <= wr_addr;
                mem_wdata <= in_data;
            end
        end
    end

endmodule
